// File: rtl/seq_multiplier_n_if.sv
// Bus bundle for the sequential shift-add multiplier.
//   master : drives start/signed_mode/data_a/data_b, observes the results
//   slave  : the multiplier itself
// Signals:
//   start         request, sampled on a rising clock edge
//   signed_mode   1 = two's-complement operands, 0 = unsigned
//   data_a/data_b multiplicand / multiplier (WIDTH bits)
//   busy          high while an operation is in flight
//   done_flag     one-cycle pulse when product_out is updated
//   product_out   registered 2*WIDTH-bit result
//   seven_segment status glyph, active-high, bit order gfedcba
interface seq_multiplier_n_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       data_a;
    logic [WIDTH-1:0]       data_b;
    logic                   busy;
    logic                   done_flag;
    logic [2*WIDTH-1:0]     product_out;
    logic [6:0]             seven_segment;

    modport master (
        output start, signed_mode, data_a, data_b,
        input  busy, done_flag, product_out, seven_segment
    );

    modport slave (
        input  start, signed_mode, data_a, data_b,
        output busy, done_flag, product_out, seven_segment
    );
endinterface

// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, consuming DIGIT
// multiplier bits per CALC cycle. Signed operation is done on magnitudes with
// the sign re-applied at completion. Fixed latency of N+2 cycles (N=WIDTH/DIGIT)
// regardless of operand values.
// Ports:
//   clk      rising-edge clock
//   reset_a  asynchronous active-high reset
//   bus      seq_multiplier_n_if slave modport (start, signed_mode, data_a,
//            data_b in; busy, done_flag, product_out, seven_segment out)
module seq_multiplier_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic              clk,
    input  logic              reset_a,
    seq_multiplier_n_if.slave bus
);

    localparam int N     = WIDTH / DIGIT;
    localparam int PW    = 2 * WIDTH;
    // At least 4 bits so the low nibble can always feed the hex glyph.
    localparam int CNT_W = ($clog2(N) + 1 > 4) ? ($clog2(N) + 1) : 4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic [PW-1:0]      mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [PW-1:0]      acc_q,     acc_d;
    logic               neg_q,     neg_d;
    logic [PW-1:0]      product_q, product_d;
    logic               done_q,    done_d;

    // |v| when signed, v otherwise; the most-negative value maps onto
    // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sm);
        if (sm && v[WIDTH-1])
            magnitude = ~v + WIDTH'(1);
        else
            magnitude = v;
    endfunction

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: hex_glyph = 7'b0111111;
            4'h1: hex_glyph = 7'b0000110;
            4'h2: hex_glyph = 7'b1011011;
            4'h3: hex_glyph = 7'b1001111;
            4'h4: hex_glyph = 7'b1100110;
            4'h5: hex_glyph = 7'b1101101;
            4'h6: hex_glyph = 7'b1111101;
            4'h7: hex_glyph = 7'b0000111;
            4'h8: hex_glyph = 7'b1111111;
            4'h9: hex_glyph = 7'b1101111;
            4'hA: hex_glyph = 7'b1110111;
            4'hB: hex_glyph = 7'b1111100;
            4'hC: hex_glyph = 7'b0111001;
            4'hD: hex_glyph = 7'b1011110;
            4'hE: hex_glyph = 7'b1111001;
            default: hex_glyph = 7'b1110001;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d  = PW'(magnitude(bus.data_a, bus.signed_mode));
                    mplier_d = magnitude(bus.data_b, bus.signed_mode);
                    neg_d    = bus.signed_mode &
                               (bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                // The multiplicand is pre-shifted and the multiplier shifted
                // down, so the current digit always sits in the low DIGIT bits.
                acc_d    = acc_q + mcand_q * PW'(mplier_q[DIGIT-1:0]);
                mcand_d  = mcand_q << DIGIT;
                mplier_d = mplier_q >> DIGIT;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST)
                    state_d = S_DONE;
            end
            S_DONE: begin
                product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.seven_segment = 7'b0000000;
        case (state_q)
            S_CALC:  bus.seven_segment = hex_glyph(count_q[3:0]);
            S_DONE:  bus.seven_segment = 7'b1011110;
            default: bus.seven_segment = 7'b0000000;
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done_flag   = done_q;
    assign bus.product_out = product_q;

endmodule
